// File: rtl/defuse_flood_scan_if.sv
// Click/board bus between the Saper game controller and the flood-fill sequencer.
interface defuse_flood_scan_if #(
  parameter int BOARD_MAX = 16
);
  logic [1:0]                            level;
  logic                                  new_game;
  logic                                  start;
  logic [4:0]                            click_x;
  logic [4:0]                            click_y;
  logic [BOARD_MAX-1:0][BOARD_MAX-1:0]   mine_arr;
  logic [BOARD_MAX-1:0][BOARD_MAX-1:0]   defuse_arr;
  logic                                  busy;
  logic                                  done;
  logic                                  explode;

  modport master (
    output level, new_game, start, click_x, click_y, mine_arr,
    input  defuse_arr, busy, done, explode
  );

  modport slave (
    input  level, new_game, start, click_x, click_y, mine_arr,
    output defuse_arr, busy, done, explode
  );
endinterface

// File: rtl/defuse_flood_scan.sv
// Flood-fill sequencer: seeds the clicked field, then rasters the board one field per cycle until a pass opens nothing; DEFUSE_FLOOD_DIAG_EN selects 8-neighbour flood (default 4).
// Latency start->done is 2+P*(N*N+1)+1 cycles (3 for mine/out-of-range); start and new_game are dropped while busy.
module defuse_flood_scan #(
  parameter int BOARD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  defuse_flood_scan_if.slave bus
);

  localparam int IW = $clog2(BOARD_MAX);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEED     = 3'd1;
  localparam logic [2:0] S_SCAN     = 3'd2;
  localparam logic [2:0] S_PASS_END = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

`ifdef DEFUSE_FLOOD_DIAG_EN
  localparam bit DIAG_EN = 1'b1;
`else
  localparam bit DIAG_EN = 1'b0;
`endif

  logic [2:0] state_q, state_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [4:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0] lvl_q, lvl_d;
  logic       changed_q, changed_d;
  logic       mine_hit_q, mine_hit_d;
  logic       done_q, done_d;
  logic       explode_q, explode_d;
  logic [BOARD_MAX-1:0][BOARD_MAX-1:0] defuse_q, defuse_d;

  logic [4:0] n;
  logic [3:0] cnt;
  logic       flood;

  function automatic logic in_rng(input int px, input int py, input logic [4:0] lim);
    return (px >= 0) && (py >= 0) && (px < int'(lim)) && (py < int'(lim));
  endfunction

  always_comb begin
    case (lvl_q)
      2'd1:    n = 5'd8;
      2'd2:    n = 5'd10;
      2'd3:    n = 5'd16;
      default: n = 5'd0;
    endcase
  end

  // Mine count always spans all 8 neighbours, independent of the flood shape.
  always_comb begin
    int px, py;
    px  = 0;
    py  = 0;
    cnt = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        px = int'(x_q) + dx;
        py = int'(y_q) + dy;
        if ((dx != 0 || dy != 0) && in_rng(px, py, n) && bus.mine_arr[IW'(px)][IW'(py)])
          cnt = cnt + 4'd1;
      end
    end
  end

  assign flood = (state_q == S_SCAN) && defuse_q[IW'(x_q)][IW'(y_q)]
               && !bus.mine_arr[IW'(x_q)][IW'(y_q)] && (cnt == 4'd0);

  always_comb begin
    int nx, ny;
    nx         = 0;
    ny         = 0;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    lvl_d      = lvl_q;
    changed_d  = changed_q;
    mine_hit_d = mine_hit_q;
    defuse_d   = defuse_q;
    done_d     = 1'b0;
    explode_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.new_game) begin
          defuse_d = '0;
        end else if (bus.start && bus.level != 2'd0) begin
          cx_d       = bus.click_x;
          cy_d       = bus.click_y;
          lvl_d      = bus.level;
          mine_hit_d = 1'b0;
          state_d    = S_SEED;
        end
      end
      S_SEED: begin
        if (!in_rng(int'(cx_q), int'(cy_q), n)) begin
          state_d = S_FINISH;
        end else if (bus.mine_arr[IW'(cx_q)][IW'(cy_q)]) begin
          mine_hit_d = 1'b1;
          state_d    = S_FINISH;
        end else begin
          defuse_d[IW'(cx_q)][IW'(cy_q)] = 1'b1;
          x_d       = '0;
          y_d       = '0;
          changed_d = 1'b0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (flood) begin
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              nx = int'(x_q) + dx;
              ny = int'(y_q) + dy;
              if ((dx != 0 || dy != 0) && (DIAG_EN || dx == 0 || dy == 0)
                  && in_rng(nx, ny, n) && !bus.mine_arr[IW'(nx)][IW'(ny)]) begin
                if (!defuse_q[IW'(nx)][IW'(ny)])
                  changed_d = 1'b1;
                defuse_d[IW'(nx)][IW'(ny)] = 1'b1;
              end
            end
          end
        end
        if (x_q == n - 5'd1) begin
          x_d = '0;
          if (y_q == n - 5'd1)
            state_d = S_PASS_END;
          else
            y_d = y_q + 5'd1;
        end else begin
          x_d = x_q + 5'd1;
        end
      end
      S_PASS_END: begin
        if (changed_q) begin
          changed_d = 1'b0;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_SCAN;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d    = 1'b1;
        explode_d = mine_hit_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      lvl_q      <= '0;
      changed_q  <= 1'b0;
      mine_hit_q <= 1'b0;
      done_q     <= 1'b0;
      explode_q  <= 1'b0;
      defuse_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      lvl_q      <= lvl_d;
      changed_q  <= changed_d;
      mine_hit_q <= mine_hit_d;
      done_q     <= done_d;
      explode_q  <= explode_d;
      defuse_q   <= defuse_d;
    end
  end

  assign bus.defuse_arr = defuse_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.explode    = explode_q;

endmodule

// File: tb/tb_defuse_flood_scan.sv
// Scoreboarded bench for defuse_flood_scan: a behavioural sweep model predicts opened fields, pass count and latency per click.
module tb_defuse_flood_scan;

  typedef logic [15:0][15:0] board_t;
  typedef struct {
    int     lat;
    logic   expl;
    board_t arr;
    int     passes;
  } exp_t;

`ifdef DEFUSE_FLOOD_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  board_t cur;
  board_t mines;
  exp_t   sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  defuse_flood_scan_if #(.BOARD_MAX(16)) bus ();
  defuse_flood_scan #(.BOARD_MAX(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.mine_arr = mines;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nsz(input logic [1:0] l);
    case (l)
      2'd1:    return 8;
      2'd2:    return 10;
      2'd3:    return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int mcnt(input board_t m, input int n, input int x, input int y);
    int c, nx, ny;
    c = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++) begin
        nx = x + dx;
        ny = y + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 && nx < n && ny < n && m[nx][ny])
          c++;
      end
    return c;
  endfunction

  // Sweep model: raster passes with in-place opening until a pass opens nothing.
  task automatic model(input logic [1:0] l, input int cx, input int cy, output exp_t e);
    int n, p, nx, ny;
    bit ch;
    board_t a;
    n = nsz(l);
    a = cur;
    p = 0;
    e.expl = 1'b0;
    if (cx >= n || cy >= n) begin
      e.lat = 3;
    end else if (mines[cx][cy]) begin
      e.expl = 1'b1;
      e.lat  = 3;
    end else begin
      a[cx][cy] = 1'b1;
      do begin
        p++;
        ch = 1'b0;
        for (int y = 0; y < n; y++)
          for (int x = 0; x < n; x++)
            if (a[x][y] && !mines[x][y] && mcnt(mines, n, x, y) == 0)
              for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                  nx = x + dx;
                  ny = y + dy;
                  if ((dx != 0 || dy != 0) && (DIAG || dx == 0 || dy == 0) &&
                      nx >= 0 && ny >= 0 && nx < n && ny < n && !mines[nx][ny]) begin
                    if (!a[nx][ny]) ch = 1'b1;
                    a[nx][ny] = 1'b1;
                  end
                end
      end while (ch);
      e.lat = 2 + p * (n * n + 1) + 1;
    end
    e.arr    = a;
    e.passes = p;
    cur      = a;
  endtask

  task automatic run_op(input logic [1:0] l, input logic [4:0] cx, input logic [4:0] cy,
                        input bit disturb);
    exp_t e, g;
    int   s, lat;
    bit   seen;
    model(l, int'(cx), int'(cy), e);
    sb.push_back(e);
    @(negedge clk);
    bus.level   = l;
    bus.click_x = cx;
    bus.click_y = cy;
    bus.start   = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_seed", bus.busy, 1);
    if (disturb) begin
      repeat (3) @(negedge clk);
      bus.start   = 1'b1;
      bus.click_x = 5'd0;
      bus.click_y = 5'd0;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
      bus.level    = 2'd3;
    end
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    lat = cyc - s;
    chk("done_seen", seen, 1);
    g = sb.pop_front();
    if (seen) begin
      chk("latency", lat, g.lat);
      chk("explode", bus.explode, g.expl);
      chk("busy_at_done", bus.busy, 0);
      chk("defuse_arr", bus.defuse_arr, g.arr);
    end
    $display("op level=%0d click=(%0d,%0d) passes=%0d latency=%0d", l, cx, cy, g.passes, lat);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("explode_pulse", bus.explode, 0);
  endtask

  task automatic clear_board();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    cur = '0;
    chk("new_game_clear", bus.defuse_arr, 0);
  endtask

  initial begin
    int dn;
    bus.level    = 2'd0;
    bus.new_game = 1'b0;
    bus.start    = 1'b0;
    bus.click_x  = 5'd0;
    bus.click_y  = 5'd0;
    mines        = '0;
    cur          = '0;
    #3;
    chk("rst_defuse", bus.defuse_arr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_explode", bus.explode, 0);
    @(negedge clk);
    rst = 1'b1;

    // Abort a level-3 sweep with reset, then rerun it to completion.
    @(negedge clk);
    bus.level = 2'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_defuse", bus.defuse_arr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("no_stale_done", dn, 0);
    run_op(2'd3, 5'd0, 5'd0, 1'b0);

    clear_board();
    run_op(2'd1, 5'd3, 5'd3, 1'b0);

    clear_board();
    for (int y = 0; y < 8; y++) mines[4][y] = 1'b1;
    run_op(2'd1, 5'd0, 5'd0, 1'b0);

    mines = '0;
    mines[5][5] = 1'b1;
    run_op(2'd2, 5'd5, 5'd5, 1'b0);

    clear_board();
    mines = '0;
    mines[3][3] = 1'b1;
    run_op(2'd1, 5'd2, 5'd2, 1'b1);

    run_op(2'd1, 5'd9, 5'd0, 1'b0);
    run_op(2'd1, 5'd0, 5'd8, 1'b0);

    // start with no game selected must be ignored
    @(negedge clk);
    bus.level = 2'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("lvl0_busy", bus.busy, 0);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("lvl0_no_done", dn, 0);

    // new_game beats a coincident start
    @(negedge clk);
    bus.level    = 2'd1;
    bus.click_x  = 5'd2;
    bus.click_y  = 5'd2;
    bus.start    = 1'b1;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    cur = '0;
    chk("ng_start_busy", bus.busy, 0);
    chk("ng_start_clear", bus.defuse_arr, cur);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("ng_start_no_done", dn, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
